// File: rtl/i2c_deglitch_ctrl_if.sv
// rtl/i2c_deglitch_ctrl_if.sv - config handshake, pad and cell-control signals of the deglitch controller
interface i2c_deglitch_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_wr;
    logic             cfg_ds;
    logic             cfg_byp;
    logic             cfg_busy;
    logic             cfg_ack;
    logic             scl_raw;
    logic             sda_raw;
    logic             scl_flt;
    logic             sda_flt;
    logic             dgl_ds;
    logic             dgl_byp;
    logic             dgl_sb;
    logic             scl_out;
    logic             sda_out;
    logic             cnt_clr;
    logic [CNT_W-1:0] raw_edg_cnt;
    logic [CNT_W-1:0] flt_edg_cnt;

    modport master (
        output cfg_wr, cfg_ds, cfg_byp, scl_raw, sda_raw, scl_flt, sda_flt, cnt_clr,
        input  cfg_busy, cfg_ack, dgl_ds, dgl_byp, dgl_sb, scl_out, sda_out,
               raw_edg_cnt, flt_edg_cnt
    );

    modport slave (
        input  cfg_wr, cfg_ds, cfg_byp, scl_raw, sda_raw, scl_flt, sda_flt, cnt_clr,
        output cfg_busy, cfg_ack, dgl_ds, dgl_byp, dgl_sb, scl_out, sda_out,
               raw_edg_cnt, flt_edg_cnt
    );
endinterface

// File: rtl/i2c_deglitch_ctrl.sv
// rtl/i2c_deglitch_ctrl.sv - I2C pad deglitch cell controller; SCL edge counters built only with DGL_EDGE_CNT_EN
module i2c_deglitch_ctrl #(
    parameter int INIT_CYC   = 8,
    parameter int IDLE_CYC   = 16,
    parameter int SETTLE_CYC = 32,
    parameter int CNT_W      = 8
) (
    input logic               clk,
    input logic               rst,
    i2c_deglitch_ctrl_if.slave bus
);
    localparam int IW = $clog2(INIT_CYC + 1);
    localparam int DW = $clog2(IDLE_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_WAIT_IDLE,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] init_cnt;
    logic [DW-1:0] idle_cnt;
    logic [SW-1:0] settle_cnt;
    logic          scl_s1, scl_s2, sda_s1, sda_s2;
    logic          pend_ds, pend_byp;
    logic          dgl_ds_q, dgl_byp_q, dgl_sb_q, ack_q;
    logic          busy, mask, cfg_take, settle_exit;
    logic          bus_high, init_done, idle_ok, settle_done;

    assign bus_high    = bus.scl_raw & bus.sda_raw;
    assign init_done   = (init_cnt == IW'(INIT_CYC - 1));
    assign idle_ok     = (idle_cnt == DW'(IDLE_CYC));
    assign settle_done = (settle_cnt == SW'(SETTLE_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        mask        = 1'b0;
        cfg_take    = 1'b0;
        settle_exit = 1'b0;
        case (state)
            ST_INIT: begin
                mask = 1'b1;
                if (init_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b0;
                if (bus.cfg_wr) begin
                    cfg_take  = 1'b1;
                    state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (idle_ok) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                mask = 1'b1;
                // a low raw line may be a START, so never hold it behind the mask
                if (settle_done || !bus_high) begin
                    settle_exit = 1'b1;
                    state_nxt   = ST_RUN;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt   <= '0;
            idle_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == ST_INIT && !init_done) init_cnt <= init_cnt + IW'(1);
            if (state == ST_INIT || !bus_high) idle_cnt <= '0;
            else if (!idle_ok)                 idle_cnt <= idle_cnt + DW'(1);
            if (state != ST_SETTLE)            settle_cnt <= '0;
            else if (!settle_done)             settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dgl_sb_q  <= 1'b0;
            dgl_ds_q  <= 1'b1;
            dgl_byp_q <= 1'b0;
            pend_ds   <= 1'b1;
            pend_byp  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            if (state == ST_INIT && init_done) dgl_sb_q <= 1'b1;
            if (cfg_take) begin
                pend_ds  <= bus.cfg_ds;
                pend_byp <= bus.cfg_byp;
            end
            if (state == ST_APPLY) begin
                dgl_ds_q  <= pend_ds;
                dgl_byp_q <= pend_byp;
            end
            ack_q <= settle_exit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_flt;
            scl_s2 <= scl_s1;
            sda_s1 <= bus.sda_flt;
            sda_s2 <= sda_s1;
        end
    end

    assign bus.cfg_busy = busy;
    assign bus.cfg_ack  = ack_q;
    assign bus.dgl_ds   = dgl_ds_q;
    assign bus.dgl_byp  = dgl_byp_q;
    assign bus.dgl_sb   = dgl_sb_q;
    assign bus.scl_out  = mask | scl_s2;
    assign bus.sda_out  = mask | sda_s2;

`ifdef DGL_EDGE_CNT_EN
    logic             scl_raw_q, scl_s3, cnt_en;
    logic [CNT_W-1:0] raw_cnt, flt_cnt;

    assign cnt_en = (state == ST_RUN) || (state == ST_WAIT_IDLE) || (state == ST_SETTLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_raw_q <= 1'b1;
            scl_s3    <= 1'b1;
            raw_cnt   <= '0;
            flt_cnt   <= '0;
        end else begin
            scl_raw_q <= bus.scl_raw;
            scl_s3    <= scl_s2;
            if (bus.cnt_clr) begin
                raw_cnt <= '0;
                flt_cnt <= '0;
            end else if (cnt_en) begin
                if ((bus.scl_raw ^ scl_raw_q) && raw_cnt != '1) raw_cnt <= raw_cnt + CNT_W'(1);
                if ((scl_s2 ^ scl_s3) && flt_cnt != '1)         flt_cnt <= flt_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.raw_edg_cnt = raw_cnt;
    assign bus.flt_edg_cnt = flt_cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr  = bus.cnt_clr;
    assign bus.raw_edg_cnt = '0;
    assign bus.flt_edg_cnt = '0;
`endif
endmodule

// File: tb/tb_i2c_deglitch_ctrl.sv
// tb/tb_i2c_deglitch_ctrl.sv - randomized self-checking bench for i2c_deglitch_ctrl
module tb_i2c_deglitch_ctrl;
    localparam int N = 140;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic cur_ds  = 1'b1;
    logic cur_byp = 1'b0;

    logic scl_p [N];
    logic sda_p [N];
    logic wr_p  [N];
    logic ds_p  [N];
    logic byp_p [N];

    i2c_deglitch_ctrl_if #(.CNT_W(8)) bus ();

    i2c_deglitch_ctrl #(
        .INIT_CYC  (8),
        .IDLE_CYC  (16),
        .SETTLE_CYC(32),
        .CNT_W     (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_high();
        bus.scl_raw = 1'b1;
        bus.sda_raw = 1'b1;
        bus.scl_flt = 1'b1;
        bus.sda_flt = 1'b1;
    endtask

    // mode 0: idle bus, mode 1: busy bus with a second request, mode 2: START during settle
    task automatic run_cfg(input int mode);
        int   w, a, e, busy_end, abort_at, run;
        int   runlen [N];
        logic ds, byp, found, exp_mask;

        for (int c = 0; c < N; c++) begin
            scl_p[c] = 1'b1;
            sda_p[c] = 1'b1;
            wr_p[c]  = 1'b0;
            ds_p[c]  = 1'b0;
            byp_p[c] = 1'b0;
        end
        scl_p[0] = 1'b0;
        ds  = 1'($urandom_range(0, 1));
        byp = 1'($urandom_range(0, 1));
        if (mode == 1) begin
            w        = $urandom_range(2, 10);
            busy_end = w + $urandom_range(10, 40);
            for (int c = 1; c <= busy_end; c++) scl_p[c] = ((c / 10) % 2 == 1);
            wr_p[w + 3]  = 1'b1;
            ds_p[w + 3]  = ~ds;
            byp_p[w + 3] = ~byp;
        end else begin
            w = $urandom_range(17, 30);
        end
        wr_p[w]  = 1'b1;
        ds_p[w]  = ds;
        byp_p[w] = byp;

        run = 0;
        for (int c = 0; c < N; c++) begin
            run       = (scl_p[c] && sda_p[c]) ? run + 1 : 0;
            runlen[c] = run;
        end
        a     = -1;
        found = 1'b0;
        for (int c = w + 1; c < N; c++) begin
            if (!found && runlen[c-1] >= 16) begin
                a     = c;
                found = 1'b1;
            end
        end
        if (a < 0 || a + 40 >= N) begin
            n_tests++;
            n_fail++;
            $display("FAIL plan: apply cycle %0d out of range", a);
            return;
        end
        if (mode == 2) begin
            abort_at = a + 1 + $urandom_range(1, 30);
            for (int c = abort_at; c < abort_at + 3; c++) sda_p[c] = 1'b0;
        end
        e     = a + 33;
        found = 1'b0;
        for (int c = a + 2; c <= a + 33; c++) begin
            if (!found && !(scl_p[c] && sda_p[c])) begin
                e     = c;
                found = 1'b1;
            end
        end

        for (int c = 0; c < N; c++) begin
            bus.scl_raw = scl_p[c];
            bus.sda_raw = sda_p[c];
            bus.scl_flt = scl_p[c];
            bus.sda_flt = sda_p[c];
            bus.cfg_wr  = wr_p[c];
            bus.cfg_ds  = ds_p[c];
            bus.cfg_byp = byp_p[c];
            tick();
            exp_mask = (c >= a + 1) && (c < e);
            check($sformatf("m%0d ds@%0d", mode, c), 32'(bus.dgl_ds), 32'((c >= a + 1) ? ds : cur_ds));
            check($sformatf("m%0d byp@%0d", mode, c), 32'(bus.dgl_byp), 32'((c >= a + 1) ? byp : cur_byp));
            check($sformatf("m%0d busy@%0d", mode, c), 32'(bus.cfg_busy), 32'((c >= w) && (c < e)));
            check($sformatf("m%0d ack@%0d", mode, c), 32'(bus.cfg_ack), 32'(c == e));
            if (c > 0) begin
                check($sformatf("m%0d scl_out@%0d", mode, c), 32'(bus.scl_out), 32'(exp_mask | scl_p[c-1]));
                check($sformatf("m%0d sda_out@%0d", mode, c), 32'(bus.sda_out), 32'(exp_mask | sda_p[c-1]));
            end
        end
        bus.cfg_wr = 1'b0;
        cur_ds     = ds;
        cur_byp    = byp;
`ifndef DGL_EDGE_CNT_EN
        check("raw_cnt tied", 32'(bus.raw_edg_cnt), 32'd0);
        check("flt_cnt tied", 32'(bus.flt_edg_cnt), 32'd0);
`endif
    endtask

    initial begin
        int acks;

        bus.cfg_wr  = 1'b0;
        bus.cfg_ds  = 1'b0;
        bus.cfg_byp = 1'b0;
        bus.cnt_clr = 1'b0;
        bus.scl_raw = 1'b1;
        bus.sda_raw = 1'b1;
        bus.scl_flt = 1'b0;
        bus.sda_flt = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        check("rst sb", 32'(bus.dgl_sb), 32'd0);
        check("rst ds", 32'(bus.dgl_ds), 32'd1);
        check("rst byp", 32'(bus.dgl_byp), 32'd0);
        check("rst busy", 32'(bus.cfg_busy), 32'd1);
        check("rst ack", 32'(bus.cfg_ack), 32'd0);
        check("rst scl_out", 32'(bus.scl_out), 32'd1);
        check("rst sda_out", 32'(bus.sda_out), 32'd1);
        check("rst raw_cnt", 32'(bus.raw_edg_cnt), 32'd0);
        check("rst flt_cnt", 32'(bus.flt_edg_cnt), 32'd0);

        // requests raised during INIT must be dropped
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bus.cfg_wr = (k <= 8);
            bus.cfg_ds = 1'b0;
            tick();
            check($sformatf("init sb@%0d", k), 32'(bus.dgl_sb), 32'(k >= 8));
            check($sformatf("init busy@%0d", k), 32'(bus.cfg_busy), 32'(k < 8));
            check($sformatf("init scl_out@%0d", k), 32'(bus.scl_out), 32'(k < 8));
            check($sformatf("init sda_out@%0d", k), 32'(bus.sda_out), 32'(k < 8));
            check($sformatf("init ds@%0d", k), 32'(bus.dgl_ds), 32'd1);
        end
        bus.cfg_wr = 1'b0;
        drive_high();
        repeat (4) tick();

        for (int i = 0; i < 12; i++) run_cfg(i % 3);

`ifdef DGL_EDGE_CNT_EN
        drive_high();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        tick();
        check("clr raw", 32'(bus.raw_edg_cnt), 32'd0);
        check("clr flt", 32'(bus.flt_edg_cnt), 32'd0);
        repeat (5) begin
            bus.scl_raw = 1'b0;
            tick();
            bus.scl_raw = 1'b1;
            tick();
            tick();
        end
        check("pulses raw", 32'(bus.raw_edg_cnt), 32'd10);
        check("pulses flt", 32'(bus.flt_edg_cnt), 32'd0);
        repeat (4) begin
            bus.scl_flt = ~bus.scl_flt;
            tick();
            tick();
        end
        repeat (3) tick();
        check("flt toggles", 32'(bus.flt_edg_cnt), 32'd4);
        check("raw steady", 32'(bus.raw_edg_cnt), 32'd10);
        bus.scl_raw = 1'b0;
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        check("clr beats edge", 32'(bus.raw_edg_cnt), 32'd0);
        tick();
        check("no edge held", 32'(bus.raw_edg_cnt), 32'd0);
        bus.scl_raw = 1'b1;
        tick();
        check("edge after clr", 32'(bus.raw_edg_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            bus.scl_raw = ~bus.scl_raw;
            tick();
        end
        check("raw saturate", 32'(bus.raw_edg_cnt), 32'd255);
        check("flt after clr", 32'(bus.flt_edg_cnt), 32'd0);
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        tick();
        check("final clr raw", 32'(bus.raw_edg_cnt), 32'd0);
        drive_high();
        repeat (4) tick();
`endif

        // reset while waiting for an idle bus
        bus.scl_raw = 1'b0;
        bus.cfg_wr  = 1'b1;
        bus.cfg_ds  = ~cur_ds;
        bus.cfg_byp = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
        repeat (5) tick();
        check("wait busy", 32'(bus.cfg_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst ds", 32'(bus.dgl_ds), 32'd1);
        check("midrst byp", 32'(bus.dgl_byp), 32'd0);
        check("midrst sb", 32'(bus.dgl_sb), 32'd0);
        drive_high();
        acks = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (bus.cfg_ack) acks++;
        end
        check("midrst no ack", 32'(acks), 32'd0);
        check("midrst ds kept", 32'(bus.dgl_ds), 32'd1);
        check("midrst sb up", 32'(bus.dgl_sb), 32'd1);
        cur_ds  = 1'b1;
        cur_byp = 1'b0;

        for (int i = 0; i < 3; i++) run_cfg(i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
